axi_channel_chunk_serializer: RTL and testbench



---
 rtl/axi_channel_chunk_serializer.sv | 65 ++++++
 tb/tb_axi_channel_chunk_serializer.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_channel_chunk_serializer.sv
// axi_channel_chunk_serializer: splits one wide valid/ready beat into CHUNK_WIDTH-bit beats,
// least-significant chunk first, with a per-beat chunk count and packet-last propagation.
module axi_channel_chunk_serializer #(
    parameter int IN_CHUNKS   = 4,
    parameter int CHUNK_WIDTH = 32,
    parameter int CNT_WIDTH   = 3
) (
    input  logic                             aclk,
    input  logic                             areset,
    input  logic                             valid_src,
    output logic                             ready_src,
    input  logic [IN_CHUNKS*CHUNK_WIDTH-1:0] payload_src,
    input  logic [CNT_WIDTH-1:0]             nchunks_src,
    input  logic                             last_src,
    output logic                             valid_dst,
    input  logic                             ready_dst,
    output logic [CHUNK_WIDTH-1:0]           payload_dst,
    output logic                             last_dst
);
    localparam int IW = $clog2(IN_CHUNKS);

    logic                             r_en;
    logic                             r_busy;
    logic                             r_last;
    logic [IW-1:0]                    r_idx;
    logic [CNT_WIDTH-1:0]             r_neff;
    logic [IN_CHUNKS*CHUNK_WIDTH-1:0] r_payload;
    logic [CNT_WIDTH-1:0]             w_neff;
    logic                             w_at_end;
    logic                             w_accept;

    always_comb begin
        w_neff      = (nchunks_src == '0 || nchunks_src > CNT_WIDTH'(IN_CHUNKS)) ? CNT_WIDTH'(IN_CHUNKS) : nchunks_src;
        w_at_end    = CNT_WIDTH'(r_idx) == r_neff - CNT_WIDTH'(1);
        // a new beat may load in the same cycle the final chunk of the current one leaves
        ready_src   = r_en && (!r_busy || (ready_dst && w_at_end));
        w_accept    = valid_src && ready_src;
        valid_dst   = r_busy;
        payload_dst = r_busy ? r_payload[int'(r_idx)*CHUNK_WIDTH +: CHUNK_WIDTH] : '0;
        last_dst    = r_busy && r_last && w_at_end;
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_en      <= 1'b0;
            r_busy    <= 1'b0;
            r_idx     <= '0;
            r_neff    <= '0;
            r_last    <= 1'b0;
            r_payload <= '0;
        end else begin
            r_en <= 1'b1;
            if (w_accept) begin
                r_busy    <= 1'b1;
                r_idx     <= '0;
                r_neff    <= w_neff;
                r_last    <= last_src;
                r_payload <= payload_src;
            end else if (r_busy && ready_dst) begin
                if (w_at_end) r_busy <= 1'b0;
                else r_idx <= r_idx + IW'(1);
            end
        end
    end
endmodule

// File: tb/tb_axi_channel_chunk_serializer.sv
// tb_axi_channel_chunk_serializer: directed scenarios plus randomized traffic against a chunk-queue model.
module tb_axi_channel_chunk_serializer;
    localparam int IC = 4;
    localparam int CW = 32;
    localparam int NW = 3;

    logic               aclk = 1'b0;
    logic               areset = 1'b1;
    logic               valid_src = 1'b0;
    logic               ready_src;
    logic [IC*CW-1:0]   payload_src = '0;
    logic [NW-1:0]      nchunks_src = '0;
    logic               last_src = 1'b0;
    logic               valid_dst;
    logic               ready_dst = 1'b0;
    logic [CW-1:0]      payload_dst;
    logic               last_dst;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [CW-1:0] d;
        logic          l;
    } chunk_t;
    chunk_t q[$];

    axi_channel_chunk_serializer #(.IN_CHUNKS(IC), .CHUNK_WIDTH(CW), .CNT_WIDTH(NW)) dut (
        .aclk(aclk), .areset(areset),
        .valid_src(valid_src), .ready_src(ready_src), .payload_src(payload_src),
        .nchunks_src(nchunks_src), .last_src(last_src),
        .valid_dst(valid_dst), .ready_dst(ready_dst), .payload_dst(payload_dst), .last_dst(last_dst)
    );

    always #5 aclk = ~aclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic set_beat(input logic [IC*CW-1:0] p, input logic [NW-1:0] n, input logic l);
        valid_src   = 1'b1;
        payload_src = p;
        nchunks_src = n;
        last_src    = l;
    endtask

    task automatic push_beat(input logic [IC*CW-1:0] p, input logic [NW-1:0] n, input logic l);
        int ne;
        chunk_t c;
        ne = (n == 0 || n > IC) ? IC : int'(n);
        for (int k = 0; k < ne; k++) begin
            c.d = p[k*CW +: CW];
            c.l = l && (k == ne - 1);
            q.push_back(c);
        end
    endtask

    task automatic test_reset();
        set_beat({96'h0, 32'hA5A5_0001}, 3'd1, 1'b0);
        ready_dst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge aclk);
            vectors++;
            if (ready_src !== 1'b0 || valid_dst !== 1'b0 || payload_dst !== '0 || last_dst !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_outputs: ready_src=%b valid_dst=%b payload_dst=%h last_dst=%b, required all 0", ready_src, valid_dst, payload_dst, last_dst);
            end
        end
        @(posedge aclk); #1 areset = 1'b0;
        @(negedge aclk);
        vectors++;
        if (ready_src !== 1'b0) begin
            miscompares++;
            $display("FAIL enable_delay: ready_src=%b, required 0", ready_src);
        end
        @(negedge aclk);
        vectors++;
        if (ready_src !== 1'b1 || valid_dst !== 1'b0) begin
            miscompares++;
            $display("FAIL enable_set: ready_src=%b valid_dst=%b, required 1 0", ready_src, valid_dst);
        end
        @(posedge aclk); #1 valid_src = 1'b0;
        @(negedge aclk);
        vectors++;
        if (valid_dst !== 1'b1 || payload_dst !== 32'hA5A5_0001 || last_dst !== 1'b0) begin
            miscompares++;
            $display("FAIL first_accept: valid=%b payload=%h last=%b, required 1 a5a50001 0", valid_dst, payload_dst, last_dst);
        end
        @(posedge aclk); #1;
    endtask

    task automatic test_full_beat();
        logic [IC*CW-1:0] p;
        p = 128'h44444444_33333333_22222222_11111111;
        set_beat(p, 3'd0, 1'b1);
        ready_dst = 1'b1;
        @(negedge aclk);
        vectors++;
        if (ready_src !== 1'b1 || valid_dst !== 1'b0) begin
            miscompares++;
            $display("FAIL full_idle: ready_src=%b valid_dst=%b, required 1 0", ready_src, valid_dst);
        end
        @(posedge aclk); #1 valid_src = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge aclk);
            vectors++;
            if (valid_dst !== 1'b1 || payload_dst !== p[k*CW +: CW] || last_dst !== (k == 3)) begin
                miscompares++;
                $display("FAIL full_chunk%0d: valid=%b payload=%h last=%b, required 1 %h %b", k, valid_dst, payload_dst, last_dst, p[k*CW +: CW], k == 3);
            end
            @(posedge aclk); #1;
        end
        @(negedge aclk);
        vectors++;
        if (valid_dst !== 1'b0) begin
            miscompares++;
            $display("FAIL full_end: valid_dst=%b, required 0", valid_dst);
        end
        @(posedge aclk); #1;
    endtask

    task automatic test_back_to_back();
        logic [IC*CW-1:0] a, b;
        logic [CW-1:0] exp_d[5];
        a = {$urandom, $urandom, $urandom, $urandom};
        b = {$urandom, $urandom, $urandom, $urandom};
        exp_d = '{a[0 +: CW], a[CW +: CW], b[0 +: CW], b[CW +: CW], b[2*CW +: CW]};
        ready_dst = 1'b1;
        set_beat(a, 3'd2, 1'b0);
        @(posedge aclk); #1 set_beat(b, 3'd3, 1'b1);
        for (int k = 0; k < 5; k++) begin
            @(negedge aclk);
            vectors++;
            if (valid_dst !== 1'b1 || payload_dst !== exp_d[k] || last_dst !== (k == 4)) begin
                miscompares++;
                $display("FAIL b2b_chunk%0d: valid=%b payload=%h last=%b, required 1 %h %b", k, valid_dst, payload_dst, last_dst, exp_d[k], k == 4);
            end
            if (k < 2) begin
                vectors++;
                if (ready_src !== (k == 1)) begin
                    miscompares++;
                    $display("FAIL b2b_ready%0d: ready_src=%b, required %b", k, ready_src, k == 1);
                end
            end
            @(posedge aclk); #1;
            if (k == 1) valid_src = 1'b0;
        end
        @(negedge aclk);
        vectors++;
        if (valid_dst !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_end: valid_dst=%b, required 0", valid_dst);
        end
        @(posedge aclk); #1;
    endtask

    task automatic test_backpressure();
        logic [IC*CW-1:0] p;
        p = {$urandom, $urandom, $urandom, $urandom};
        ready_dst = 1'b1;
        set_beat(p, 3'd4, 1'b1);
        @(posedge aclk); #1 valid_src = 1'b0;
        @(negedge aclk);
        vectors++;
        if (payload_dst !== p[0 +: CW]) begin
            miscompares++;
            $display("FAIL bp_chunk0: payload=%h, required %h", payload_dst, p[0 +: CW]);
        end
        @(posedge aclk); #1 ready_dst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge aclk);
            vectors++;
            if (valid_dst !== 1'b1 || payload_dst !== p[CW +: CW] || last_dst !== 1'b0 || ready_src !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_hold%0d: valid=%b payload=%h last=%b ready_src=%b, required 1 %h 0 0", i, valid_dst, payload_dst, last_dst, ready_src, p[CW +: CW]);
            end
            @(posedge aclk); #1;
        end
        ready_dst = 1'b1;
        for (int k = 1; k < 4; k++) begin
            @(negedge aclk);
            vectors++;
            if (valid_dst !== 1'b1 || payload_dst !== p[k*CW +: CW] || last_dst !== (k == 3)) begin
                miscompares++;
                $display("FAIL bp_resume%0d: valid=%b payload=%h last=%b, required 1 %h %b", k, valid_dst, payload_dst, last_dst, p[k*CW +: CW], k == 3);
            end
            @(posedge aclk); #1;
        end
    endtask

    task automatic test_clamp();
        logic [IC*CW-1:0] p;
        int n;
        p = {$urandom, $urandom, $urandom, $urandom};
        n = 0;
        ready_dst = 1'b1;
        set_beat(p, 3'd7, 1'b0);
        @(posedge aclk); #1 valid_src = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge aclk);
            if (valid_dst) begin
                vectors++;
                if (n >= IC || payload_dst !== p[(n % IC)*CW +: CW]) begin
                    miscompares++;
                    $display("FAIL clamp_chunk%0d: payload=%h, required %h (count limit %0d)", n, payload_dst, p[(n % IC)*CW +: CW], IC);
                end
                n++;
            end
            @(posedge aclk); #1;
        end
        vectors++;
        if (n != IC) begin
            miscompares++;
            $display("FAIL clamp_count: emitted %0d chunks, required %0d", n, IC);
        end
    endtask

    task automatic test_single_stream();
        logic [IC*CW-1:0] p[3];
        for (int i = 0; i < 3; i++) p[i] = {$urandom, $urandom, $urandom, $urandom};
        ready_dst = 1'b1;
        set_beat(p[0], 3'd1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge aclk);
            vectors++;
            if (i > 0 && (valid_dst !== 1'b1 || payload_dst !== p[i-1][0 +: CW] || last_dst !== 1'b1 || ready_src !== 1'b1)) begin
                miscompares++;
                $display("FAIL single%0d: valid=%b payload=%h last=%b ready_src=%b, required 1 %h 1 1", i - 1, valid_dst, payload_dst, last_dst, ready_src, p[i-1][0 +: CW]);
            end else if (i == 0 && ready_src !== 1'b1) begin
                miscompares++;
                $display("FAIL single_idle: ready_src=%b, required 1", ready_src);
            end
            @(posedge aclk); #1;
            if (i < 2) set_beat(p[i+1], 3'd1, 1'b1);
            else valid_src = 1'b0;
        end
        @(negedge aclk);
        vectors++;
        if (valid_dst !== 1'b0) begin
            miscompares++;
            $display("FAIL single_end: valid_dst=%b, required 0", valid_dst);
        end
        @(posedge aclk); #1;
    endtask

    task automatic test_random();
        bit pending;
        logic exp_ready;
        pending = 1'b0;
        q.delete();
        for (int c = 0; c < 3000; c++) begin
            if (!pending) begin
                if ($urandom_range(0, 9) < 7) begin
                    set_beat({$urandom, $urandom, $urandom, $urandom}, NW'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
                    pending = 1'b1;
                end else valid_src = 1'b0;
            end
            ready_dst = ($urandom_range(0, 9) < 7);
            @(negedge aclk);
            exp_ready = (q.size() == 0) || (ready_dst && q.size() == 1);
            vectors++;
            if (valid_dst !== (q.size() > 0) || ready_src !== exp_ready) begin
                miscompares++;
                $display("FAIL rand_hs cycle %0d: valid_dst=%b ready_src=%b, required %b %b", c, valid_dst, ready_src, q.size() > 0, exp_ready);
            end
            if (q.size() > 0) begin
                vectors++;
                if (payload_dst !== q[0].d || last_dst !== q[0].l) begin
                    miscompares++;
                    $display("FAIL rand_data cycle %0d: payload=%h last=%b, required %h %b", c, payload_dst, last_dst, q[0].d, q[0].l);
                end
                if (ready_dst) void'(q.pop_front());
            end
            if (valid_src && exp_ready) begin
                push_beat(payload_src, nchunks_src, last_src);
                pending = 1'b0;
            end
            @(posedge aclk); #1;
        end
        valid_src = 1'b0;
        ready_dst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge aclk);
            vectors++;
            if (valid_dst !== (q.size() > 0) || (q.size() > 0 && (payload_dst !== q[0].d || last_dst !== q[0].l))) begin
                miscompares++;
                $display("FAIL rand_drain%0d: valid=%b payload=%h last=%b, queue depth %0d", i, valid_dst, payload_dst, last_dst, q.size());
            end
            if (q.size() > 0) void'(q.pop_front());
            @(posedge aclk); #1;
        end
    endtask

    task automatic test_mid_reset();
        logic [IC*CW-1:0] p;
        p = {$urandom, $urandom, $urandom, $urandom};
        ready_dst = 1'b1;
        set_beat(p, 3'd4, 1'b1);
        @(posedge aclk); #1 valid_src = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge aclk);
            vectors++;
            if (payload_dst !== p[k*CW +: CW]) begin
                miscompares++;
                $display("FAIL mrst_chunk%0d: payload=%h, required %h", k, payload_dst, p[k*CW +: CW]);
            end
            if (k < 2) begin
                @(posedge aclk); #1;
            end
        end
        #1 areset = 1'b1;
        #1;
        vectors++;
        if (valid_dst !== 1'b0 || payload_dst !== '0 || last_dst !== 1'b0 || ready_src !== 1'b0) begin
            miscompares++;
            $display("FAIL mrst_async: valid=%b payload=%h last=%b ready_src=%b, required all 0", valid_dst, payload_dst, last_dst, ready_src);
        end
        @(posedge aclk); #1 areset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge aclk);
            vectors++;
            if (valid_dst !== 1'b0) begin
                miscompares++;
                $display("FAIL mrst_stale%0d: valid_dst=%b payload=%h, required 0", i, valid_dst, payload_dst);
            end
            @(posedge aclk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_full_beat();
        test_back_to_back();
        test_backpressure();
        test_clamp();
        test_single_stream();
        test_random();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
